stream_mux_n: RTL and testbench
===============================

# stream_mux_n

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes, packet locking and a selectable static or round-robin arbitration mode. It sits between the per-channel feature/weight streams of the CNN engine and a single downstream consumer, such as a PE row or buffer writer. It replaces fixed 4-input select muxing wherever the selected source must be held for a whole packet and the output must be registered for timing.

## Interface
- DataWidth, 8, width of one data beat
- NumCh, 4, number of input channels (2..16)
- SelWidth, $clog2(NumCh), width of channel index signals
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- mode  input  1  0 = static select via sel, 1 = round-robin
- sel  input  SelWidth  channel index used in static mode
- in_valid  input  NumCh  per-channel beat valid
- in_ready  output  NumCh  per-channel beat accepted this cycle
- in_data  input  NumCh*DataWidth  channel i occupies bits [i*DataWidth +: DataWidth]
- in_last  input  NumCh  per-channel end-of-packet flag
- out_valid  output  1  registered output beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  DataWidth  registered beat data
- out_last  output  1  registered end-of-packet flag
- out_ch  output  SelWidth  index of the channel that produced the current output beat
- busy  output  1  high while a packet is locked (state LOCKED)

## Operation
- Two-state FSM, IDLE and LOCKED, plus a grant register grant and a round-robin pointer rr_ptr.
- Output stage has one register. It can load when load_en = !out_valid || out_ready.
- Candidate selection in IDLE:
  - Static mode: the candidate is sel, and only if sel < NumCh and in_valid[sel]=1. If sel >= NumCh there is never a candidate.
  - Round-robin mode: the candidate is the first i with in_valid[i]=1, searching from rr_ptr+1 upward and wrapping modulo NumCh. If no channel is valid there is no candidate.
- Candidate selection in LOCKED: the candidate is always grant. mode and sel are ignored until the packet ends.
- in_ready[i] = load_en && (i == candidate). At most one bit of in_ready is high at any time. in_ready is combinational from in_valid, mode, sel and the FSM state.
- Beat acceptance: a beat is accepted when in_valid[c] && in_ready[c]. The output register then loads in_data[c], in_last[c] and out_ch=c, and out_valid is set to 1.
- If no beat is accepted and out_ready=1, out_valid clears to 0. out_data, out_last and out_ch hold their values.
- FSM transitions on an accepted beat:
  - IDLE with last=0: go to LOCKED, grant=c.
  - IDLE with last=1: stay IDLE, rr_ptr=c.
  - LOCKED with last=1: go to IDLE, rr_ptr=grant.
  - LOCKED with last=0: stay LOCKED.
- rr_ptr advances only at a packet end, so round-robin fairness is per packet, not per beat.
- mode and sel are sampled only while IDLE. A change during LOCKED has no effect until the packet completes.
- busy = (state == LOCKED).

## Timing
- Reset values (rst_n low, asynchronous):
  - state=IDLE, grant=0, rr_ptr=NumCh-1 (so channel 0 wins first in round-robin).
  - out_valid=0, out_data=0, out_last=0, out_ch=0, busy=0.
  - in_ready=0 while rst_n is low.
- Latency is 1 cycle: a beat accepted at edge k appears on out_* after edge k with out_valid=1.
- Throughput is 1 beat/cycle while out_ready=1, including back-to-back single-beat packets from different channels.
- Backpressure:
  - With out_valid=1 and out_ready=0, out_* hold stable and all in_ready=0.
  - Beats are never dropped or duplicated.
- Simultaneous events: output consumption and a new load in the same cycle is legal (load_en covers this). The new beat replaces the old one with out_valid staying 1.
- Boundary cases:
  - A granted channel dropping in_valid mid-packet stalls the mux in LOCKED. No other channel is served.
  - Single-beat packets (last=1 on the first beat) never enter LOCKED.
  - rr_ptr wraps from NumCh-1 to 0.
- Reset mid-packet returns to IDLE immediately and discards the output register contents.

## Test plan
- Reset: assert rst_n=0 mid-stream -> out_valid=0, out_data=0, out_ch=0, busy=0, in_ready=0 on the same cycle; after release, round-robin with all channels valid grants channel 0 first.
- Static mode: mode=0, sel=2, ch2 sends a 3-beat packet 0x11,0x22,0x33 (last on 0x33) with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, out_ch=2, busy high for the first two beats; sel=5 with NumCh=4 -> in_ready stays 0.
- Round-robin fairness: mode=1, all 4 channels continuously valid with 1-beat packets -> out_ch sequence 0,1,2,3,0,1; no bubbles in out_valid.
- Packet lock: mode=1, ch1 in a 4-beat packet while ch0/ch3 are valid, and sel/mode toggled mid-packet -> all 4 beats come from ch1 with no interleave; the next grant is ch3, then ch0.
- Backpressure: out_ready low for 5 cycles mid-packet -> out_data stable, all in_ready=0; after release, the remaining beats arrive in order with no loss or duplication.
- Stall in LOCKED: the granted ch2 deasserts valid for 3 cycles mid-packet while ch0 is valid -> no beats from ch0, busy=1 throughout, and ch2 resumes when its valid returns.

Source files
------------

// File: rtl/stream_mux_n.sv
// stream_mux_n -- N-to-1 streaming multiplexer with packet locking.
//
// Selects one of NumCh valid/ready input streams and forwards it through a
// single registered output stage. Once a multi-beat packet starts, the
// source channel is locked until its last beat. In IDLE the source is either
// taken from sel (static mode) or chosen round-robin, one packet per turn.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode                0 = static select via sel, 1 = round-robin
//   sel                 channel index used in static mode
//   in_valid/in_ready   per-channel handshake (in_ready is one-hot or zero)
//   in_data             channel i at bits [i*DataWidth +: DataWidth]
//   in_last             per-channel end-of-packet flag
//   out_valid/out_ready registered output handshake
//   out_data, out_last  registered beat and end-of-packet flag
//   out_ch              channel that produced the current output beat
//   busy                high while a packet is locked
module stream_mux_n #(
  parameter int DataWidth = 8,
  parameter int NumCh     = 4,
  parameter int SelWidth  = $clog2(NumCh)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mode,
  input  logic [SelWidth-1:0]        sel,
  input  logic [NumCh-1:0]           in_valid,
  output logic [NumCh-1:0]           in_ready,
  input  logic [NumCh*DataWidth-1:0] in_data,
  input  logic [NumCh-1:0]           in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DataWidth-1:0]       out_data,
  output logic                       out_last,
  output logic [SelWidth-1:0]        out_ch,
  output logic                       busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [SelWidth-1:0]   grant;
  logic [SelWidth-1:0]   rr_ptr;

  logic                  load_en;
  logic                  cand_vld;
  logic [SelWidth-1:0]   cand;
  logic [DataWidth-1:0]  cand_data;
  logic                  cand_last;
  logic                  accept;

  assign load_en = !out_valid || out_ready;

  // Candidate selection
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    if (state == LOCKED) begin
      cand     = grant;
      cand_vld = 1'b1;
    end else if (!mode) begin
      // An out-of-range sel matches no channel, so there is no candidate.
      for (int i = 0; i < NumCh; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          cand     = SelWidth'(i);
          cand_vld = 1'b1;
        end
      end
    end else begin
      // Walk from the farthest offset down to rr_ptr+1 so the nearest
      // valid channel after rr_ptr is the last one written and wins.
      for (int k = NumCh; k >= 1; k--) begin
        for (int i = 0; i < NumCh; i++) begin
          if (i == (int'(rr_ptr) + k) % NumCh && in_valid[i]) begin
            cand     = SelWidth'(i);
            cand_vld = 1'b1;
          end
        end
      end
    end
  end

  // Handshake and beat mux
  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    cand_last = 1'b0;
    for (int i = 0; i < NumCh; i++) begin
      // rst_n gating keeps in_ready low during reset even though the
      // empty output stage would otherwise allow a load.
      in_ready[i] = rst_n && load_en && cand_vld && (int'(cand) == i);
      if (int'(cand) == i) begin
        cand_data = in_data[i*DataWidth +: DataWidth];
        cand_last = in_last[i];
      end
    end
  end

  assign accept = |(in_ready & in_valid);

  // Output register and packet FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= SelWidth'(NumCh - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        out_last  <= cand_last;
        out_ch    <= cand;
        case (state)
          IDLE: begin
            if (cand_last) begin
              rr_ptr <= cand;
            end else begin
              state <= LOCKED;
              grant <= cand;
            end
          end
          LOCKED: begin
            if (cand_last) begin
              state  <= IDLE;
              rr_ptr <= grant;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

  localparam int DataWidth = 8;
  localparam int NumCh     = 4;
  localparam int SelWidth  = 3;  // wide enough to drive an out-of-range sel

  logic                       clk;
  logic                       rst_n;
  logic                       mode;
  logic [SelWidth-1:0]        sel;
  logic [NumCh-1:0]           in_valid;
  logic [NumCh-1:0]           in_ready;
  logic [NumCh*DataWidth-1:0] in_data;
  logic [NumCh-1:0]           in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [DataWidth-1:0]       out_data;
  logic                       out_last;
  logic [SelWidth-1:0]        out_ch;
  logic                       busy;

  logic [DataWidth-1:0]       dat [NumCh];

  int checks   = 0;
  int failures = 0;

  stream_mux_n #(
    .DataWidth(DataWidth),
    .NumCh    (NumCh),
    .SelWidth (SelWidth)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_ch   (out_ch),
    .busy     (busy)
  );

  always_comb in_data = {dat[3], dat[2], dat[1], dat[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required end of stimulus");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input int ch,
                      input logic l, input logic b);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_ch"},    32'(out_ch),    32'(ch));
    check({tag, "_last"},  32'(out_last),  32'(l));
    check({tag, "_busy"},  32'(busy),      32'(b));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < NumCh; i++) dat[i] = 8'hA0 + 8'(i);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_ch",    32'(out_ch),    32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_ready", 32'(in_ready),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);

    // Round-robin, all channels valid, single-beat packets.
    for (int n = 0; n < 6; n++) begin
      tick();
      beat($sformatf("rr%0d", n), 8'hA0 + 8'(n % 4), n % 4, 1'b1, 1'b0);
      if (n < 5) check($sformatf("rr%0d_next_ready", n), 32'(in_ready), 32'(1 << ((n + 1) % 4)));
    end

    // Reset while a packet from ch2 is locked.
    in_last = 4'h0;
    tick();
    beat("pre_rst", 8'hA2, 2, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data",  32'(out_data),  32'd0);
    check("midrst_ch",    32'(out_ch),    32'd0);
    check("midrst_busy",  32'(busy),      32'd0);
    check("midrst_ready", 32'(in_ready),  32'd0);
    tick();
    rst_n   = 1'b1;
    in_last = 4'hF;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'b0001);
    tick();
    beat("post_rst", 8'hA0, 0, 1'b1, 1'b0);

    // Static select of ch2, 3-beat packet.
    mode     = 1'b0;
    sel      = 3'd2;
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    dat[2]   = 8'h11;
    #1;
    check("st_ready", 32'(in_ready), 32'b0100);
    tick();
    beat("st0", 8'h11, 2, 1'b0, 1'b1);
    dat[2] = 8'h22;
    tick();
    beat("st1", 8'h22, 2, 1'b0, 1'b1);
    dat[2]  = 8'h33;
    in_last = 4'b0100;
    tick();
    beat("st2", 8'h33, 2, 1'b1, 1'b0);

    // Out-of-range sel never yields a candidate.
    sel      = 3'd5;
    in_valid = 4'hF;
    in_last  = 4'hF;
    #1;
    check("sel5_ready0", 32'(in_ready), 32'd0);
    tick();
    check("sel5_valid", 32'(out_valid), 32'd0);
    check("sel5_ready1", 32'(in_ready), 32'd0);

    // Packet lock on ch1 with mode/sel toggled mid-packet.
    mode     = 1'b1;
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    dat[1]   = 8'h41;
    tick();
    beat("lk0", 8'h41, 1, 1'b0, 1'b1);
    in_valid = 4'b1011;
    mode     = 1'b0;
    sel      = 3'd0;
    dat[1]   = 8'h42;
    #1;
    check("lk_ready", 32'(in_ready), 32'b0010);
    tick();
    beat("lk1", 8'h42, 1, 1'b0, 1'b1);
    mode   = 1'b1;
    sel    = 3'd3;
    dat[1] = 8'h43;
    tick();
    beat("lk2", 8'h43, 1, 1'b0, 1'b1);
    dat[1]  = 8'h44;
    in_last = 4'b1011;
    tick();
    beat("lk3", 8'h44, 1, 1'b1, 1'b0);
    in_valid = 4'b1001;
    dat[0]   = 8'h70;
    dat[3]   = 8'h73;
    #1;
    check("lk_next_ready", 32'(in_ready), 32'b1000);
    tick();
    beat("lk_next3", 8'h73, 3, 1'b1, 1'b0);
    tick();
    beat("lk_next0", 8'h70, 0, 1'b1, 1'b0);

    // Backpressure mid-packet on ch0.
    in_valid = 4'b0001;
    in_last  = 4'b0000;
    dat[0]   = 8'h51;
    tick();
    beat("bp0", 8'h51, 0, 1'b0, 1'b1);
    out_ready = 1'b0;
    dat[0]    = 8'h52;
    #1;
    check("bp_ready", 32'(in_ready), 32'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      beat($sformatf("bp_hold%0d", n), 8'h51, 0, 1'b0, 1'b1);
      check($sformatf("bp_hold%0d_ready", n), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    beat("bp1", 8'h52, 0, 1'b0, 1'b1);
    dat[0] = 8'h53;
    tick();
    beat("bp2", 8'h53, 0, 1'b0, 1'b1);
    dat[0]  = 8'h54;
    in_last = 4'b0001;
    tick();
    beat("bp3", 8'h54, 0, 1'b1, 1'b0);

    // Granted ch2 stalls mid-packet while ch0 is valid.
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    dat[2]   = 8'h61;
    tick();
    beat("sl0", 8'h61, 2, 1'b0, 1'b1);
    in_valid = 4'b0001;
    in_last  = 4'b0001;
    dat[0]   = 8'h99;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("sl_gap%0d_valid", n), 32'(out_valid), 32'd0);
      check($sformatf("sl_gap%0d_busy", n),  32'(busy),      32'd1);
      check($sformatf("sl_gap%0d_ready", n), 32'(in_ready),  32'b0100);
    end
    in_valid = 4'b0101;
    in_last  = 4'b0101;
    dat[2]   = 8'h62;
    tick();
    beat("sl1", 8'h62, 2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
